cpc_ram_bank_ctrl: RTL and testbench
====================================

Name: cpc_ram_bank_ctrl

Overview:
Z80-bus front end for the CPC RAM expansion. Decodes I/O writes to the gate-array port (&7Fxx, data[7:6]=11) and holds the RAM configuration (mode + 64K bank) in a hex register stage. Maps each CPU memory access (quadrant adr[15:14]) to expansion or internal RAM. Its outputs feed the expansion RAM address and select logic and the internal-RAM disable line.

Parameters:
BANK_W, 3, width of the expansion bank field (data[5:3]); 3 gives 512K.

Ports:
clock  in  1  Z80 CPU clock (4 MHz); all state on rising edge
resetb  in  1  asynchronous, active-low reset
iorq_b  in  1  Z80 IORQ, active-low
wr_b  in  1  Z80 WR, active-low
m1_b  in  1  Z80 M1, active-low; excludes interrupt-acknowledge cycles
mreq_b  in  1  Z80 MREQ, active-low
adr  in  16  Z80 address bus
data  in  8  Z80 data bus
cfg_mode  out  3  registered config mode 0-7
cfg_bank  out  BANK_W(+3 with XADR_EN)  registered expansion bank
cfg_stb  out  1  one-cycle pulse on each config update
ext_sel  out  1  current access hits an expansion block
ext_page  out  2  16K page within the selected 64K bank
ext_bank  out  width of cfg_bank  bank for the current access (= cfg_bank)
int_remap  out  1  access maps to internal block 3 (mode 3, quadrant 1)
ramdis  out  1  disable internal RAM: ext_sel & ~mreq_b

Behaviour:
- Reset (async, resetb=0): cfg_mode=0, cfg_bank=0, cfg_stb=0, FSM=IDLE, iow_q=0, data_q=0. ext_sel=0, int_remap=0, ramdis=0 under mode 0.
- Strobe: iow = ~iorq_b & ~wr_b & m1_b & ~adr[15] & adr[14] & (data[7:6]==2'b11).
- Edge E1: iow registered into iow_q; data (plus adr[10:8] with XADR_EN) registered into data_q.
- FSM IDLE: iow_q=1 at edge E2 -> cfg_mode<=data_q[2:0], cfg_bank<=data_q[3+:BANK_W], cfg_stb=1 for that cycle, go BUSY.
- FSM BUSY: stay while iow_q=1 (one update per I/O cycle); iow_q=0 -> IDLE.
- Latency: the new mapping is visible after E2, two edges after the strobe is first sampled.
- Gate-array writes with data[7:6]!=11 (pen, ink, mode/ROM): ignored, no cfg_stb.
- Mapping (combinational from registered cfg and adr[15:14]); quadrants q0..q3 per mode, Xn = expansion page n-4:
  - mode 0: 0,1,2,3
  - mode 1: 0,1,2,X7
  - mode 2: X4,X5,X6,X7
  - mode 3: 0,3,2,X7
  - mode 4..7: 0,X(mode),2,3
- Expansion hit: ext_sel=1, ext_page=n-4.
- Internal hit: ext_sel=0, ext_page=quadrant.
- Mode 3, q1: int_remap=1, ext_page=3.
- Mapping is independent of rd_b/wr_b. ROM-overlay arbitration is downstream.
- Reset mid-write: cfg returns to 0 immediately. A strobe still asserted after release reloads from IDLE (one update).
- A bank change mid-memory-access takes effect at the next edge. No glitch suppression beyond the registered cfg.

Optional Feature:
- XADR_EN defined: cfg_bank widens by 3; its upper bits are ~adr[10:8], captured with data. Port &7Fxx gives 0, so behaviour matches base mode; &7Exx..&78xx select banks 1..7 of a 4MB space.
- XADR_EN undefined: adr[10:8] is ignored and cfg_bank is BANK_W bits.

Decomposition:
- Shared package: GA_CFG_CODE=2'b11, FSM state encoding (IDLE/BUSY), the 8x4 mode-map table (ext flag, page), the int_remap constant.
- One sub-module: cpc_bank_map, the pure combinational map (cfg_mode, adr[15:14] -> ext_sel, ext_page, int_remap). Registers and FSM stay in the top level.

Test Plan:
- Reset, then read at adr=&C000 with mreq_b=0 -> ext_sel=0, ext_page=3, ramdis=0, cfg_mode=0.
- OUT &7F00,&C4 (3-cycle IORQ/WR) -> cfg_mode=4, cfg_bank=0, single cfg_stb pulse after E2. Access &4000 -> ext_sel=1, ext_page=0, ramdis=1.
- OUT &7F00,&D2 -> mode 2, bank 2. Accesses &0000/&4000/&8000/&C000 -> ext_page 0/1/2/3, all ext_sel=1, ext_bank=2.
- OUT &7F00,&8C (mode/ROM write) and an interrupt ack (m1_b=0, iorq_b=0) -> config unchanged, no cfg_stb.
- OUT &7F00,&C3, then &4000 -> int_remap=1, ext_sel=0; &C000 -> ext_sel=1, ext_page=3.
- resetb pulsed low mid-IORQ after &C7 is latched -> cfg_mode=0 asynchronously. With XADR_EN, OUT &7E00,&C4 -> cfg_bank=6'b001000.

Source files
------------

// File: rtl/cpc_ram_bank_ctrl_pkg.sv
// ============================================================================
// Module   : cpc_ram_bank_ctrl_pkg
// Brief    : Shared constants, FSM encoding and mode-map table for the CPC
//            RAM expansion bank controller. XADR_EN widens the bank field.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cpc_ram_bank_ctrl_pkg;

  localparam logic [1:0] GA_CFG_CODE = 2'b11;

`ifdef XADR_EN
  localparam int XADR_W = 3;
`else
  localparam int XADR_W = 0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       ext;
    logic [1:0] page;
  } map_t;

  localparam map_t I0 = '{ext: 1'b0, page: 2'd0};
  localparam map_t I1 = '{ext: 1'b0, page: 2'd1};
  localparam map_t I2 = '{ext: 1'b0, page: 2'd2};
  localparam map_t I3 = '{ext: 1'b0, page: 2'd3};
  localparam map_t X4 = '{ext: 1'b1, page: 2'd0};
  localparam map_t X5 = '{ext: 1'b1, page: 2'd1};
  localparam map_t X6 = '{ext: 1'b1, page: 2'd2};
  localparam map_t X7 = '{ext: 1'b1, page: 2'd3};

  // Indexed by {mode, quadrant}
  localparam map_t MODE_MAP [32] = '{
    I0, I1, I2, I3,
    I0, I1, I2, X7,
    X4, X5, X6, X7,
    I0, I3, I2, X7,
    I0, X4, I2, I3,
    I0, X5, I2, I3,
    I0, X6, I2, I3,
    I0, X7, I2, I3
  };

  localparam logic [2:0] REMAP_MODE = 3'd3;
  localparam logic [1:0] REMAP_QUAD = 2'd1;

endpackage

`default_nettype wire

// File: rtl/cpc_ram_bank_ctrl_map.sv
// ============================================================================
// Module   : cpc_bank_map
// Brief    : Combinational quadrant map: config mode + adr[15:14] to
//            expansion select, page and internal-remap flag.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpc_bank_map
  import cpc_ram_bank_ctrl_pkg::*;
(
  input  logic [2:0] i_mode,
  input  logic [1:0] i_quad,
  output logic       o_ext_sel,
  output logic [1:0] o_ext_page,
  output logic       o_int_remap
);

  map_t w_entry;

  assign w_entry     = MODE_MAP[{i_mode, i_quad}];
  assign o_ext_sel   = w_entry.ext;
  assign o_ext_page  = w_entry.page;
  assign o_int_remap = (i_mode == REMAP_MODE) && (i_quad == REMAP_QUAD);

endmodule

`default_nettype wire

// File: rtl/cpc_ram_bank_ctrl.sv
// ============================================================================
// Module   : cpc_ram_bank_ctrl
// Brief    : Z80 front end for the CPC RAM expansion: decodes gate-array
//            config writes and maps memory quadrants. Option: XADR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpc_ram_bank_ctrl
  import cpc_ram_bank_ctrl_pkg::*;
#(
  parameter int BANK_W = 3
) (
  input  logic                       clock,
  input  logic                       resetb,
  input  logic                       iorq_b,
  input  logic                       wr_b,
  input  logic                       m1_b,
  input  logic                       mreq_b,
  input  logic [15:0]                adr,
  input  logic [7:0]                 data,
  output logic [2:0]                 cfg_mode,
  output logic [BANK_W+XADR_W-1:0]   cfg_bank,
  output logic                       cfg_stb,
  output logic                       ext_sel,
  output logic [1:0]                 ext_page,
  output logic [BANK_W+XADR_W-1:0]   ext_bank,
  output logic                       int_remap,
  output logic                       ramdis
);

  localparam int DQ_W = 3 + BANK_W + XADR_W;

  logic            w_iow;
  logic [DQ_W-1:0] w_data_d;
  logic            r_iow_q;
  logic [DQ_W-1:0] r_data_q;
  state_t          r_state;
  logic            w_unused;

  assign w_iow = ~iorq_b & ~wr_b & m1_b & ~adr[15] & adr[14]
               & (data[7:6] == GA_CFG_CODE);

  // Extended bank bits are inverted so port &7Fxx lands on bank group 0
`ifdef XADR_EN
  assign w_data_d = {~adr[10:8], data[2+BANK_W:0]};
`else
  assign w_data_d = data[2+BANK_W:0];
`endif

  assign w_unused = &{1'b0, adr, data};

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_iow_q  <= 1'b0;
      r_data_q <= '0;
    end else begin
      r_iow_q  <= w_iow;
      r_data_q <= w_data_d;
    end
  end

  // One config update per I/O cycle: BUSY holds until the strobe drops
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state  <= ST_IDLE;
      cfg_mode <= 3'd0;
      cfg_bank <= '0;
      cfg_stb  <= 1'b0;
    end else begin
      cfg_stb <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (r_iow_q) begin
            cfg_mode <= r_data_q[2:0];
            cfg_bank <= r_data_q[DQ_W-1:3];
            cfg_stb  <= 1'b1;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!r_iow_q) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  cpc_bank_map u_map (
    .i_mode      (cfg_mode),
    .i_quad      (adr[15:14]),
    .o_ext_sel   (ext_sel),
    .o_ext_page  (ext_page),
    .o_int_remap (int_remap)
  );

  assign ext_bank = cfg_bank;
  assign ramdis   = ext_sel & ~mreq_b;

endmodule

`default_nettype wire

// File: tb/tb_cpc_ram_bank_ctrl.sv
// ============================================================================
// Module   : tb_cpc_ram_bank_ctrl
// Brief    : Scoreboard bench for cpc_ram_bank_ctrl with a block-number
//            reference model; honours XADR_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpc_ram_bank_ctrl;

  localparam int BANK_W = 3;
`ifdef XADR_EN
  localparam int XW = 3;
`else
  localparam int XW = 0;
`endif
  localparam int CBW = BANK_W + XW;

  logic           clock;
  logic           resetb;
  logic           iorq_b;
  logic           wr_b;
  logic           m1_b;
  logic           mreq_b;
  logic [15:0]    adr;
  logic [7:0]     data;
  logic [2:0]     cfg_mode;
  logic [CBW-1:0] cfg_bank;
  logic           cfg_stb;
  logic           ext_sel;
  logic [1:0]     ext_page;
  logic [CBW-1:0] ext_bank;
  logic           int_remap;
  logic           ramdis;

  cpc_ram_bank_ctrl #(.BANK_W(BANK_W)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .iorq_b    (iorq_b),
    .wr_b      (wr_b),
    .m1_b      (m1_b),
    .mreq_b    (mreq_b),
    .adr       (adr),
    .data      (data),
    .cfg_mode  (cfg_mode),
    .cfg_bank  (cfg_bank),
    .cfg_stb   (cfg_stb),
    .ext_sel   (ext_sel),
    .ext_page  (ext_page),
    .ext_bank  (ext_bank),
    .int_remap (int_remap),
    .ramdis    (ramdis)
  );

  initial clock = 1'b0;
  always #125 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0]     m_mode;
  logic [CBW-1:0] m_bank;
  logic [CBW+2:0] cfg_q[$];
  logic [CBW+4:0] acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: resolve the quadrant to an absolute 16K block 0..7 (4..7 = expansion)
  function automatic logic [3:0] ref_map(input logic [2:0] mode, input logic [1:0] q);
    int blk;
    logic [1:0] pg;
    blk = int'(q);
    case (mode)
      3'd1: if (q == 2'd3) blk = 7;
      3'd2: blk = 4 + int'(q);
      3'd3: if (q == 2'd1) blk = 3; else if (q == 2'd3) blk = 7;
      3'd4, 3'd5, 3'd6, 3'd7: if (q == 2'd1) blk = int'(mode);
      default: ;
    endcase
    pg = 2'(blk % 4);
    return {blk >= 4, pg, (mode == 3'd3) && (q == 2'd1)};
  endfunction

  function automatic logic [CBW-1:0] ref_bank(input logic [15:0] a, input logic [7:0] d);
`ifdef XADR_EN
    logic [2:0] hi;
    hi = ~a[10:8];
    return {hi, d[5:3]};
`else
    return a[0] ? d[5:3] : d[5:3];
`endif
  endfunction

  always @(negedge clock) begin
    if (resetb) begin
      if (cfg_stb) begin
        if (cfg_q.size() == 0) begin
          chk("unexpected_cfg_stb", 32'(cfg_mode), 32'hFFFF_FFFF);
        end else begin
          chk("cfg_update", 32'({cfg_mode, cfg_bank}), 32'(cfg_q.pop_front()));
        end
      end
      if (!mreq_b) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_access", 32'(adr), 32'hFFFF_FFFF);
        end else begin
          chk("access_map", 32'({ext_sel, ext_page, int_remap, ramdis, ext_bank}),
              32'(acc_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input logic m1);
    if (m1 && a[15:14] == 2'b01 && d[7:6] == 2'b11) begin
      m_mode = d[2:0];
      m_bank = ref_bank(a, d);
      cfg_q.push_back({m_mode, m_bank});
    end
    adr = a; data = d; m1_b = m1; iorq_b = 1'b0; wr_b = 1'b0;
    repeat (3) tick();
    iorq_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
    repeat (3) tick();
  endtask

  task automatic access(input logic [15:0] a);
    logic [3:0] r;
    r = ref_map(m_mode, a[15:14]);
    acc_q.push_back({r, r[3], m_bank});
    adr = a; mreq_b = 1'b0;
    tick();
    mreq_b = 1'b1;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        m1;
    resetb = 1'b0; iorq_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1; mreq_b = 1'b1;
    adr = 16'h0000; data = 8'h00;
    m_mode = 3'd0; m_bank = '0;
    #10;
    chk("reset_cfg_mode", 32'(cfg_mode), 32'd0);
    chk("reset_cfg_bank", 32'(cfg_bank), 32'd0);
    chk("reset_stb_sel",  32'({cfg_stb, ext_sel, int_remap, ramdis}), 32'd0);
    #300 resetb = 1'b1;
    tick();

    access(16'hC000);
    io_write(16'h7F00, 8'hC4, 1'b1);
    access(16'h4000);
    io_write(16'h7F00, 8'hD2, 1'b1);
    access(16'h0000); access(16'h4000); access(16'h8000); access(16'hC000);
    io_write(16'h7F00, 8'h8C, 1'b1);
    io_write(16'h7F00, 8'hC5, 1'b0);
    access(16'h4000);
    io_write(16'h7F00, 8'hC3, 1'b1);
    access(16'h4000); access(16'hC000);
`ifdef XADR_EN
    io_write(16'h7E00, 8'hC4, 1'b1);
    chk("xadr_bank", 32'(cfg_bank), 32'h08);
    access(16'h4000);
`endif

    // Async reset mid-IORQ, strobe held across release: exactly one reload
    m_mode = 3'd7; m_bank = ref_bank(16'h7F00, 8'hC7);
    cfg_q.push_back({m_mode, m_bank});
    adr = 16'h7F00; data = 8'hC7; iorq_b = 1'b0; wr_b = 1'b0;
    repeat (3) tick();
    #50 resetb = 1'b0;
    #1;
    chk("async_reset_mode", 32'(cfg_mode), 32'd0);
    chk("async_reset_bank", 32'(cfg_bank), 32'd0);
    m_mode = 3'd7; m_bank = ref_bank(16'h7F00, 8'hC7);
    cfg_q.push_back({m_mode, m_bank});
    #30 resetb = 1'b1;
    repeat (3) tick();
    iorq_b = 1'b1; wr_b = 1'b1;
    repeat (3) tick();
    access(16'h4000);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: a = 16'h7F00;
        1: a = {8'h78 | 8'($urandom_range(0, 7)), 8'($urandom)};
        2: a = {2'b01, 14'($urandom)};
        default: a = 16'($urandom);
      endcase
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) d[7:6] = 2'b11;
      m1 = ($urandom_range(0, 9) != 0);
      io_write(a, d, m1);
      for (int k = 0; k < 3; k++) access(16'($urandom));
    end

    repeat (4) tick();
    chk("cfg_queue_drained", 32'(cfg_q.size()), 32'd0);
    chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
